// File: rtl/par_rx.sv
// Receive-side FIFO of the parallel inter-router channel. It buffers upstream items, drives
// channel_busy back to the transmitter, and presents the head item first-word-fall-through.
`ifndef HDR_SZ
`define HDR_SZ 8
`endif
`ifndef PL_SZ
`define PL_SZ 16
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

// One storage word. It has no reset: contents are don't-care until written.
module par_rx_entry #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module par_rx #(
  parameter string port  = "unknown",
  parameter int    DEPTH = 4,
  localparam int   W     = `HDR_SZ + `PL_SZ + `ADDR_SZ,
  localparam int   AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  input  logic [W-1:0]  item_in,
  output logic          channel_busy,
  output logic [W-1:0]  item_out,
  output logic          empty,
  input  logic          rd,
  output logic [AW:0]   count,
  output logic          overflow
);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wp, rp;
  logic                    full, push, pop;

  // Status depends only on count, never on pointer equality.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign channel_busy = full;
  assign push         = valid && !full;
  assign pop          = rd && !empty;
  assign item_out     = mem[rp];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    par_rx_entry #(.W(W)) u_ent (
      .clk (clk),
      .we  (push && (wp == AW'(i))),
      .d   (item_in),
      .q   (mem[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Items that arrive while full are dropped. The error stays latched until reset.
      if (valid && full) begin
        overflow <= 1'b1;
        $warning("par_rx %s: overflow, dropped item %0h", port, item_in);
      end
    end
  end
endmodule

// File: tb/tb_par_rx.sv
// Testbench for par_rx: directed vector table, hand-written multi-cycle corner cases,
// and random traffic checked against a queue model.
`ifndef HDR_SZ
`define HDR_SZ 8
`endif
`ifndef PL_SZ
`define PL_SZ 16
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

module tb_par_rx;
  localparam int DEPTH = 4;
  localparam int W     = `HDR_SZ + `PL_SZ + `ADDR_SZ;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          valid = 1'b0;
  logic          rd = 1'b0;
  logic [W-1:0]  item_in = '0;
  logic          channel_busy, empty, overflow;
  logic [W-1:0]  item_out;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  par_rx #(.port("tb"), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .item_in      (item_in),
    .channel_busy (channel_busy),
    .item_out     (item_out),
    .empty        (empty),
    .rd           (rd),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic         r;
    logic [W-1:0] d;
    int           cnt;
    logic         emp;
    logic         bsy;
    logic         ovf;
    logic [W-1:0] itm;
  } vec_t;

  vec_t vt[$];
  logic [W-1:0] mq[$];
  bit           movf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic emp, input logic bsy,
                         input logic ovf, input logic [W-1:0] itm);
    chk({tag, ".count"}, 64'(count), 64'(cnt));
    chk({tag, ".empty"}, 64'(empty), 64'(emp));
    chk({tag, ".busy"}, 64'(channel_busy), 64'(bsy));
    chk({tag, ".overflow"}, 64'(overflow), 64'(ovf));
    if (!emp) chk({tag, ".item_out"}, 64'(item_out), 64'(itm));
  endtask

  // Drives one cycle of inputs and samples the outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic r, input logic [W-1:0] d);
    @(negedge clk);
    valid = v; rd = r; item_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; valid = 1'b0; rd = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mq.delete();
    movf = 1'b0;
  endtask

  // Queue model: the FIFO state before the edge decides what is accepted.
  task automatic model_step(input logic v, input logic r, input logic [W-1:0] d);
    int sz = mq.size();
    bit pop_ok  = r && (sz > 0);
    bit push_ok = v && (sz < DEPTH);
    if (v && sz == DEPTH) movf = 1'b1;
    if (pop_ok) void'(mq.pop_front());
    if (push_ok) mq.push_back(d);
  endtask

  task automatic model_cmp(input string tag);
    chk_all(tag, mq.size(), mq.size() == 0, mq.size() == DEPTH, movf,
            (mq.size() > 0) ? mq[0] : '0);
  endtask

  task automatic mstep(input string tag, input logic v, input logic r, input logic [W-1:0] d);
    step(v, r, d);
    model_step(v, r, d);
    model_cmp(tag);
  endtask

  initial begin
    // Each entry gives v, r, d, then the expected count, empty, busy, overflow and item_out.
    vt.push_back('{1, 0, 'hA5, 1, 0, 0, 0, 'hA5});
    vt.push_back('{0, 1, 'h00, 0, 1, 0, 0, 'h00});
    vt.push_back('{1, 1, 'h77, 1, 0, 0, 0, 'h77});   // push+pop while empty
    vt.push_back('{0, 1, 'h00, 0, 1, 0, 0, 'h00});
    vt.push_back('{0, 1, 'h00, 0, 1, 0, 0, 'h00});   // underflow ignored
    vt.push_back('{1, 0, 'h01, 1, 0, 0, 0, 'h01});
    vt.push_back('{1, 0, 'h02, 2, 0, 0, 0, 'h01});
    vt.push_back('{1, 0, 'h03, 3, 0, 0, 0, 'h01});
    vt.push_back('{1, 0, 'h04, 4, 0, 1, 0, 'h01});
    vt.push_back('{1, 0, 'h09, 4, 0, 1, 1, 'h01});   // overflow, 9 dropped
    vt.push_back('{1, 1, 'h05, 3, 0, 0, 1, 'h02});   // pop while full, push refused
    vt.push_back('{0, 1, 'h00, 2, 0, 0, 1, 'h03});
    vt.push_back('{0, 1, 'h00, 1, 0, 0, 1, 'h04});
    vt.push_back('{0, 1, 'h00, 0, 1, 0, 1, 'h00});

    reset = 1'b0;
    #1;
    chk_all("reset", 0, 1, 0, 0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].v, vt[i].r, vt[i].d);
      chk_all($sformatf("vec%0d", i), vt[i].cnt, vt[i].emp, vt[i].bsy, vt[i].ovf, vt[i].itm);
    end

    // Concurrent push and pop at count=2 over a pointer wrap
    do_reset();
    mstep("pp_fill", 1, 0, 'h10);
    mstep("pp_fill", 1, 0, 'h11);
    for (int i = 0; i < 10; i++) mstep($sformatf("pp%0d", i), 1, 1, W'(32'h12 + i));
    chk("pp.count_final", 64'(count), 64'd2);

    // Reset in the middle of a cycle, with count=3 and overflow latched
    do_reset();
    for (int i = 0; i < 5; i++) mstep("mr_fill", 1, 0, W'(32'h40 + i));
    mstep("mr_pop", 0, 1, '0);
    @(negedge clk);
    valid = 1'b0; rd = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_all("midreset", 0, 1, 0, 0, '0);
    @(negedge clk);
    reset = 1'b1;
    mq.delete();
    movf = 1'b0;

    // Random traffic, biased toward pushes so the FIFO fills up
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic v = ($urandom_range(0, 99) < 60);
      logic r = ($urandom_range(0, 99) < ((i < 200) ? 35 : 60));
      mstep("rand", v, r, W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule
